multdiv_iter: RTL and testbench

- Iterative signed 32-bit multiply/divide unit in the execute stage, beside the ALU.
- It consumes the same operand buses the ALU receives, holds the operation over WIDTH+1 cycles, and returns a result to the pipeline.
- The pipeline stalls on `busy`.
- Multiply is radix-2 shift-and-add; divide is restoring shift-and-subtract. Each step uses a one-bit shift per iteration.

---
 rtl/multdiv_iter.sv | 138 +++++++++++++
 tb/tb_multdiv_iter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide unit for the execute stage.
// Multiply: radix-2 shift-and-add on operand magnitudes.
// Divide: restoring shift-and-subtract on operand magnitudes.
// One iteration per clock, sign fix-up in a final cycle, WIDTH+1 cycles total.
module multdiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic               op_mul;      // 1: multiply, 0: divide
    logic               neg;         // result must be negated in FIX
    logic [WIDTH-1:0]   opnd;        // multiplicand (mult) or divisor (div) magnitude
    logic [2*WIDTH-1:0] acc;         // {hi, lo}: product accumulator or {remainder, quotient}

    logic               start;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rs;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   fix_res;
    logic               fix_exc;

    // A start on any edge wins, multiply has priority over divide.
    assign start = ctrl_MULT | ctrl_DIV;

    // Operand magnitudes; -2^(WIDTH-1) maps to itself, read as unsigned.
    always_comb begin
        a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    end

    // One iteration step and the FIX-cycle result/exception evaluation.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
        div_rs   = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_rs - {1'b0, opnd};
        if (op_mul)
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        else if (div_diff[WIDTH])
            acc_step = {div_rs[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

        prod = neg ? -acc : acc;
        quo  = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        if (op_mul) begin
            fix_res = prod[WIDTH-1:0];
            // Overflow when the top WIDTH+1 bits are not a pure sign extension.
            fix_exc = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));
        end else if (opnd == '0) begin
            fix_res = '0;
            fix_exc = 1'b1;
        end else begin
            fix_res = quo;
            fix_exc = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state: a start restarts from any state; DONE behaves as IDLE.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN:     if (cnt == LAST) state_nxt = FIX;
                FIX:     state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    // Datapath: capture on start, iterate in RUN, publish in FIX.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt            <= '0;
            op_mul         <= 1'b0;
            neg            <= 1'b0;
            opnd           <= '0;
            acc            <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start) begin
                op_mul <= ctrl_MULT;
                neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                opnd   <= ctrl_MULT ? a_mag : b_mag;
                acc    <= {{WIDTH{1'b0}}, (ctrl_MULT ? b_mag : a_mag)};
                cnt    <= '0;
                busy   <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        acc <= acc_step;
                        cnt <= cnt + 1'b1;
                    end
                    FIX: begin
                        data_result    <= fix_res;
                        data_exception <= fix_exc;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed bench for multdiv_iter: hand-computed products/quotients,
// cycle-exact RDY/busy timing, restart abort and mid-operation reset.
module tb_multdiv_iter;

    logic        clock;
    logic        reset_n;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int nvec = 0;
    int nerr = 0;

    multdiv_iter #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a start so that the next rising edge is E0; return #1 after E0.
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;  // must not disturb the captured operands
        data_operandB = $urandom;
    endtask

    // Full operation with timing checks on busy/RDY and result hold.
    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic exc);
        logic early_rdy;
        logic busy_drop;
        early_rdy = 1'b0;
        busy_drop = 1'b0;
        start_op(m, d, a, b);
        chk({tag, ".busy_e0"}, {31'd0, busy}, 32'd1);
        for (int i = 1; i <= 32; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) early_rdy = 1'b1;
            if (!busy)          busy_drop = 1'b1;
        end
        chk({tag, ".rdy_early"}, {31'd0, early_rdy}, 32'd0);
        chk({tag, ".busy_run"},  {31'd0, busy_drop}, 32'd0);
        @(posedge clock);  // E33
        #1;
        chk({tag, ".rdy"},    {31'd0, data_resultRDY}, 32'd1);
        chk({tag, ".busy"},   {31'd0, busy},           32'd0);
        chk({tag, ".result"}, data_result,             res);
        chk({tag, ".exc"},    {31'd0, data_exception}, {31'd0, exc});
        @(posedge clock);  // E34
        #1;
        chk({tag, ".rdy_off"}, {31'd0, data_resultRDY}, 32'd0);
        chk({tag, ".hold"},    data_result,             res);
    endtask

    initial begin
        logic seen;
        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #23;
        chk("rst.result", data_result,             32'd0);
        chk("rst.exc",    {31'd0, data_exception}, 32'd0);
        chk("rst.rdy",    {31'd0, data_resultRDY}, 32'd0);
        chk("rst.busy",   {31'd0, busy},           32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op("mul6x7",    1, 0, 32'd6,        32'd7,        32'h0000002A, 1'b0);
        run_op("mulm7x6",   1, 0, 32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 1'b0);
        run_op("mul_ovf",   1, 0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
        run_op("mul_max2",  1, 0, 32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1);
        run_op("mul_zero",  1, 0, 32'hDEADBEEF, 32'd0,        32'h00000000, 1'b0);
        run_op("divm43_5",  0, 1, 32'hFFFFFFD5, 32'd5,        32'hFFFFFFF8, 1'b0);
        run_op("div_by0",   0, 1, 32'd7,        32'd0,        32'h00000000, 1'b1);
        run_op("div_ovf",   0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        run_op("div_zero",  0, 1, 32'd0,        32'd9,        32'h00000000, 1'b0);
        run_op("div_neg2",  0, 1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0);

        // Restart: multiply aborted at E10 by a divide 100/7.
        start_op(1, 0, 32'd3, 32'd5);
        seen = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) seen = 1'b1;
        end
        chk("restart.rdy_pre", {31'd0, seen}, 32'd0);
        run_op("restart", 0, 1, 32'd100, 32'd7, 32'd14, 1'b0);

        // Reset in the middle of a divide: outputs clear at once, no RDY later.
        start_op(0, 1, 32'd1000, 32'd3);
        for (int i = 1; i <= 20; i++) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst.result", data_result,             32'd0);
        chk("midrst.exc",    {31'd0, data_exception}, 32'd0);
        chk("midrst.rdy",    {31'd0, data_resultRDY}, 32'd0);
        chk("midrst.busy",   {31'd0, busy},           32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY || busy) seen = 1'b1;
        end
        chk("midrst.quiet", {31'd0, seen}, 32'd0);

        // Both starts together: multiply wins.
        run_op("both", 1, 1, 32'd9, 32'd3, 32'd27, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
